axil_csr_master: RTL and testbench



---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_csr_master.sv | 237 +++++++++++++++++++++++
 tb/tb_axil_csr_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite CSR initiator.
// Optional watchdog macro used by the top: AXIL_MASTER_TIMEOUT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axil_pkg;

    // Transaction sequencer states; one transaction is in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    // AXI response codes that matter to this initiator.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write strobe width for the default data width.
    localparam int STRB_W = `DATA_WIDTH / 8;

    // Anything other than OKAY is reported to the requester as an error.
    function automatic logic respIsErr(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_csr_master.sv
// AXI4-Lite initiator that turns a command/response handshake into single
// AXI4-Lite write or read transactions towards the accelerator CSR slave.
// All outputs come straight from registers.
// Optional feature macro: AXIL_MASTER_TIMEOUT_EN (sticky watchdog flag).
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axil_csr_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = `CSR_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      timeout,

    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    // Reject unsupported configurations at elaboration time.
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_badDataWidth
        $error("axil_csr_master: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
        $error("axil_csr_master: TIMEOUT_CYCLES must fit the 16-bit wait counter");
    end

    state_t                    r_state;
    logic                      r_cmdReady;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_bready;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_rspValid;
    logic [DATA_WIDTH-1:0]     r_rspRdata;
    logic                      r_rspErr;

    logic                      w_cmdAccept;
    logic                      w_awDone;
    logic                      w_wDone;

    // A channel counts as finished once its valid has dropped or is being
    // accepted this cycle; the two write channels complete independently.
    assign w_cmdAccept = (r_state == IDLE) && cmd_valid;
    assign w_awDone    = !r_awvalid || m_axi_awready;
    assign w_wDone     = !r_wvalid  || m_axi_wready;

    // Main sequencer: latch the command, drive each AXI channel in turn and
    // hold the captured response until the requester takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr     <= cmd_addr;
                        r_wdata    <= cmd_wdata;
                        r_wstrb    <= cmd_wstrb;
                        r_cmdReady <= 1'b0;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (r_awvalid && m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_awDone && w_wDone) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_rspErr   <= respIsErr(m_axi_bresp);
                        r_rspRdata <= '0;
                        r_bready   <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rspRdata <= m_axi_rdata;
                        r_rspErr   <= respIsErr(m_axi_rresp);
                        r_rready   <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [15:0] r_waitCnt;
    logic        r_timeout;
    logic [15:0] w_waitCntNext;
    logic        w_inWait;
    logic        w_enterWait;

    // Waiting states are the ones where the slave owns the next step; the
    // counter restarts each time a new waiting state is entered.
    assign w_inWait    = (r_state == WR) || (r_state == WR_RESP) ||
                         (r_state == RD_ADDR) || (r_state == RD_DATA);
    assign w_enterWait = w_cmdAccept ||
                         ((r_state == WR) && w_awDone && w_wDone) ||
                         ((r_state == RD_ADDR) && m_axi_arready);
    assign w_waitCntNext = (r_waitCnt == 16'hFFFF) ? r_waitCnt : r_waitCnt + 16'd1;

    // Saturating watchdog with a sticky flag; the bus valids are left alone
    // so the stalled transaction stays protocol-legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_cmdAccept) begin
                r_timeout <= 1'b0;
            end
            if (w_enterWait) begin
                r_waitCnt <= '0;
            end else if (w_inWait) begin
                r_waitCnt <= w_waitCntNext;
                if (32'(w_waitCntNext) >= 32'(TIMEOUT_CYCLES)) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign cmd_ready     = r_cmdReady;
    assign rsp_valid     = r_rspValid;
    assign rsp_rdata     = r_rspRdata;
    assign rsp_err       = r_rspErr;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_csr_master.sv
// Self-checking bench for axil_csr_master with a small AXI4-Lite slave
// model, a response scoreboard and a protocol-stability monitor.
// Watchdog section is built only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_csr_master;
    import axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err, timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    rsp_t expQ[$];

    always #5 clk = ~clk;

    axil_csr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Compare one value and log a failure line when it differs.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: per-channel ready delays, strobe-aware register file,
    // and a fixed erroring location at 0x3C.
    logic [31:0] mem [0:63];
    int          awDelay = 0, wDelay = 0, arDelay = 0;
    int          awCnt, wCnt, arCnt;
    logic        slvAwGot, slvWGot;
    logic [31:0] slvAwAddr, slvWData;
    logic [3:0]  slvWStrb;
    logic        awHs, wHs, arHs, wrCommit;
    logic [31:0] wrAddr, wrData;
    logic [3:0]  wrStrb;

    assign awready  = awvalid && (awCnt >= awDelay) && !slvAwGot;
    assign wready   = wvalid && (wCnt >= wDelay) && !slvWGot;
    assign arready  = arvalid && (arCnt >= arDelay) && !rvalid;
    assign awHs     = awvalid && awready;
    assign wHs      = wvalid && wready;
    assign arHs     = arvalid && arready;
    assign wrCommit = (awHs || slvAwGot) && (wHs || slvWGot);
    assign wrAddr   = slvAwGot ? slvAwAddr : awaddr;
    assign wrData   = slvWGot ? slvWData : wdata;
    assign wrStrb   = slvWGot ? slvWStrb : wstrb;

    always @(posedge clk) begin
        if (rst) begin
            awCnt <= 0; wCnt <= 0; arCnt <= 0;
            slvAwGot <= 1'b0; slvWGot <= 1'b0;
            slvAwAddr <= '0; slvWData <= '0; slvWStrb <= '0;
            bvalid <= 1'b0; bresp <= RESP_OKAY;
            rvalid <= 1'b0; rresp <= RESP_OKAY; rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (awHs) awCnt <= 0; else if (awvalid) awCnt <= awCnt + 1;
            if (wHs) wCnt <= 0; else if (wvalid) wCnt <= wCnt + 1;
            if (arHs) arCnt <= 0; else if (arvalid) arCnt <= arCnt + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if (wrCommit) begin
                for (int b = 0; b < 4; b++)
                    if (wrStrb[b]) mem[wrAddr[7:2]][8*b +: 8] <= wrData[8*b +: 8];
                slvAwGot <= 1'b0;
                slvWGot  <= 1'b0;
                bvalid   <= 1'b1;
                bresp    <= RESP_OKAY;
            end else begin
                if (awHs) begin slvAwGot <= 1'b1; slvAwAddr <= awaddr; end
                if (wHs) begin slvWGot <= 1'b1; slvWData <= wdata; slvWStrb <= wstrb; end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arHs) begin
                rvalid <= 1'b1;
                if (araddr == 32'h3C) begin
                    rdata <= 32'h12345678;
                    rresp <= RESP_SLVERR;
                end else begin
                    rdata <= mem[araddr[7:2]];
                    rresp <= RESP_OKAY;
                end
            end
        end
    end

    // Scoreboard monitor: every response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h with no expectation queued", rsp_rdata);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Protocol monitor: a valid waiting for its ready must persist with
    // stable payload into the next cycle.
    logic        pAw, pW, pAr, pRsp;
    logic [31:0] pAwAddr, pWData, pArAddr, pRspData;
    logic [3:0]  pWStrb;
    logic        pRspErr;
    always @(negedge clk) begin
        if (rst) begin
            pAw = 0; pW = 0; pAr = 0; pRsp = 0;
        end else begin
            if (pAw) begin
                checkOutput("awvalid_held", 64'(awvalid), 64'd1);
                checkOutput("awaddr_stable", 64'(awaddr), 64'(pAwAddr));
            end
            if (pW) begin
                checkOutput("wvalid_held", 64'(wvalid), 64'd1);
                checkOutput("wdata_stable", 64'({wstrb, wdata}), 64'({pWStrb, pWData}));
            end
            if (pAr) begin
                checkOutput("arvalid_held", 64'(arvalid), 64'd1);
                checkOutput("araddr_stable", 64'(araddr), 64'(pArAddr));
            end
            if (pRsp) begin
                checkOutput("rsp_valid_held", 64'(rsp_valid), 64'd1);
                checkOutput("rsp_stable", 64'({rsp_err, rsp_rdata}), 64'({pRspErr, pRspData}));
            end
            pAw = awvalid && !awready; pAwAddr = awaddr;
            pW  = wvalid && !wready;   pWData = wdata; pWStrb = wstrb;
            pAr = arvalid && !arready; pArAddr = araddr;
            pRsp = rsp_valid && !rsp_ready; pRspData = rsp_rdata; pRspErr = rsp_err;
        end
    end

    // Present one command, wait (bounded) for acceptance, queue the expected
    // response. Returns #1 after the accept edge, i.e. in cycle 1.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [31:0] expRdata, input logic expErr);
        rsp_t e;
        bit   ok;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready stayed 0 for addr 0x%0h", addr);
        end else begin
            e.rdata = expRdata;
            e.err   = expErr;
            expQ.push_back(e);
        end
    endtask

    // Bounded wait until all queued responses have been consumed.
    task automatic drainResponses();
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int held;
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
        checkOutput("rst_rsp", 64'({rsp_err, rsp_rdata}), 64'd0);
        checkOutput("rst_addr", 64'({awaddr, araddr}), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("prot", 64'({awprot, arprot}), 64'd0);
        rst = 1'b0;
        nextCycle();

        // Best-case write with cycle-accurate checks
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        checkOutput("wr_c1_valids", 64'({awvalid, wvalid, bready}), 64'b110);
        checkOutput("wr_c1_awaddr", 64'(awaddr), 64'h10);
        checkOutput("wr_c1_cmd_ready", 64'(cmd_ready), 64'd0);
        nextCycle();
        checkOutput("wr_c2_valids", 64'({awvalid, wvalid, bready, rsp_valid}), 64'b0010);
        nextCycle();
        checkOutput("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        nextCycle();
        checkOutput("wr_c4_cmd_ready", 64'(cmd_ready), 64'd1);
        drainResponses();

        // Read back, partial-strobe write, read back merged word
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        checkOutput("rd_c1_arvalid", 64'({arvalid, rready}), 64'b10);
        nextCycle();
        checkOutput("rd_c2_rready", 64'({arvalid, rready}), 64'b01);
        nextCycle();
        checkOutput("rd_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        drainResponses();
        applyStimulus(1'b1, 32'h10, 32'h11223344, 4'h3, 32'h0, 1'b0);
        drainResponses();
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD3344, 1'b0);
        drainResponses();

        // Skewed channels: W accepted at once, AW delayed five cycles
        awDelay = 5;
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        nextCycle();
        held = 0;
        for (int i = 0; i < 20 && awvalid; i++) begin
            checkOutput("skew_wvalid_low", 64'(wvalid), 64'd0);
            checkOutput("skew_bready_low", 64'(bready), 64'd0);
            held++;
            nextCycle();
        end
        checkOutput("skew_aw_held_cycles", 64'(held), 64'd5);
        checkOutput("skew_bready_after_aw", 64'(bready), 64'd1);
        awDelay = 0;
        drainResponses();
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        drainResponses();

        // Read returning SLVERR
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 32'h12345678, 1'b1);
        drainResponses();

        // Response backpressure for seven cycles
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) nextCycle();
        for (int i = 0; i < 7; i++) begin
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
            checkOutput("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            nextCycle();
        end
        rsp_ready = 1'b1;
        checkOutput("bp_hs_cmd_ready", 64'(cmd_ready), 64'd0);
        nextCycle();
        checkOutput("bp_after_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("bp_after_cmd_ready", 64'(cmd_ready), 64'd1);
        drainResponses();

        // Reset while waiting for the write response
        applyStimulus(1'b1, 32'h30, 32'h00000055, 4'hF, 32'h0, 1'b0);
        nextCycle();
        checkOutput("mid_rst_in_wr_resp", 64'(bready), 64'd1);
        rst = 1'b1;
        nextCycle();
        checkOutput("mid_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
        checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        expQ.delete();
        nextCycle();
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 32'h12345678, 1'b1);
        drainResponses();
        checkOutput("timeout_idle", 64'(timeout), 64'd0);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Watchdog: AR held off past the eight-cycle threshold
        arDelay = 20;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("to_before", 64'({timeout, arvalid}), 64'b01);
        nextCycle();
        checkOutput("to_after", 64'({timeout, arvalid}), 64'b11);
        arDelay = 0;
        drainResponses();
        checkOutput("to_sticky", 64'(timeout), 64'd1);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 32'h12345678, 1'b1);
        checkOutput("to_cleared", 64'(timeout), 64'd0);
        drainResponses();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
